bram_bus_responder: RTL and testbench
=====================================

BRAM_BUS_RESPONDER -- requirements
Module: bram_bus_responder

Interface
REQ-001 Parameters (name, default, meaning): DEPTH_WORDS, 4096, 32-bit words of storage; LATENCY, 2, cycles valid stays low per transaction (legal 1..15); INIT_FILE, "", hex preload file, none if empty.
REQ-002 Ports (name direction width meaning), clock and reset first:
  clk  in  1  clock, all logic on rising edge;
  rst_n  in  1  reset, asynchronous, active-low;
  instr_enable  in  1  fetch request, level;
  instr_addr  in  25  fetch byte address;
  instr_valid  out  1  fetch port idle / result ready;
  instr_result  out  32  fetched word;
  data_enable  in  1  load/store request, level;
  data_rw  in  1  0 load, 1 store;
  data_oplen  in  2  0 byte, 1 half, 2 word, 3 treated as word;
  data_unsigned  in  1  zero-extend load when 1, sign-extend when 0;
  data_addr  in  25  load/store byte address;
  data_wdata  in  32  store data, low bits used for byte/half;
  data_valid  out  1  data port idle / result ready;
  data_result  out  32  load result;
  data_misaligned  out  1  one-cycle pulse on rejected misaligned access.

Function
REQ-003 Storage: single-port word array of DEPTH_WORDS words, index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap modulo depth).
REQ-004 Port acceptance: a request on a port is accepted on a rising edge where its enable=1 and its valid=1; valid drops to 0 on the following cycle.
REQ-005 Inputs (addr, rw, oplen, unsigned, wdata) are captured at acceptance; later input changes do not affect the transaction.
REQ-006 FSM states IDLE, SERVE_D, SERVE_I; one array access in flight at a time.
REQ-007 IDLE -> SERVE_D when a data request is pending; else IDLE -> SERVE_I when a fetch is pending; else stay IDLE.
REQ-008 Simultaneous acceptance on both ports: both valids drop, data served first, fetch served immediately after (SERVE_D -> SERVE_I without passing IDLE).
REQ-009 Each SERVE state lasts exactly LATENCY cycles via a 4-bit down-counter; the array is accessed in the first cycle, result registered in the last.
REQ-010 On leaving SERVE_x, result output updated and the corresponding valid returns to 1 in the same cycle; results hold until the next completion on that port.
REQ-011 Uncontended transaction: valid low for exactly LATENCY cycles; contended fetch: low for 2*LATENCY cycles.
REQ-012 Enable held high continuously: new request accepted on the first cycle valid is 1, so valid is high for exactly one cycle between back-to-back transactions.
REQ-013 Load: select byte lane addr[1:0] (byte) or half addr[1] (half), extend per data_unsigned to 32 bits; word returned unmodified.
REQ-014 Store: byte-lane write enables; byte writes lane addr[1:0] with wdata[7:0], half writes lanes addr[1]*2 +{0,1} with wdata[15:0], word writes all lanes; other lanes unchanged; data_result unchanged by stores.
REQ-015 Fetch always reads a full word at instr_addr with addr[1:0] ignored.
REQ-016 Misaligned data access (half with addr[0]=1, word with addr[1:0]!=0): no array write, data_result=0, data_misaligned=1 for the completion cycle only, timing identical to an aligned access.

Reset
REQ-017 rst_n low asynchronously forces: state IDLE, counter 0, pending flags cleared, instr_valid=1, data_valid=1, instr_result=0, data_result=0, data_misaligned=0.
REQ-018 Reset mid-transaction abandons it: an in-flight store not yet written is dropped, a written one is retained; array contents are never cleared by reset.
REQ-019 INIT_FILE loaded at elaboration only; reset does not reload.

Verification
REQ-020 Preload word 0x0=0x00500093; instr_enable pulse addr 0x0, LATENCY=2 -> instr_valid low 2 cycles, then 1 with instr_result=0x00500093.
REQ-021 Store word 0xDEADBEEF @0x10, then byte load @0x11 unsigned -> 0x000000BE; signed -> 0xFFFFFFBE; half load @0x12 signed -> 0xFFFFDEAD.
REQ-022 Byte store 0x5A @0x13 over 0xDEADBEEF, word load @0x10 -> 0x5AADBEEF.
REQ-023 Both enables asserted same edge -> data completes after 2 cycles, fetch after 4; instr_valid low 4 cycles.
REQ-024 Word store @0x22 -> data_misaligned pulses 1 cycle, word @0x20 unchanged, data_result=0.
REQ-025 rst_n low one cycle after store acceptance with LATENCY=4 -> both valids 1, results 0 immediately; subsequent fetches accepted normally.

Source files
------------

// File: rtl/bram_bus_responder_if.sv
// Request/response bundle for the fetch and load/store ports of bram_bus_responder.
// The requester drives enables and request fields; the responder drives valids and results.
interface bram_bus_if;
    logic        instr_enable;
    logic [24:0] instr_addr;
    logic        instr_valid;
    logic [31:0] instr_result;

    logic        data_enable;
    logic        data_rw;
    logic [1:0]  data_oplen;
    logic        data_unsigned;
    logic [24:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_valid;
    logic [31:0] data_result;
    logic        data_misaligned;

    modport master (
        output instr_enable, instr_addr,
        output data_enable, data_rw, data_oplen, data_unsigned, data_addr, data_wdata,
        input  instr_valid, instr_result,
        input  data_valid, data_result, data_misaligned
    );

    modport slave (
        input  instr_enable, instr_addr,
        input  data_enable, data_rw, data_oplen, data_unsigned, data_addr, data_wdata,
        output instr_valid, instr_result,
        output data_valid, data_result, data_misaligned
    );
endinterface

// File: rtl/bram_bus_responder.sv
// Single-port word RAM shared by a fetch port and a load/store port.
// Data requests win arbitration; each access occupies the RAM for LATENCY cycles.
module bram_bus_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2,
    parameter     INIT_FILE   = ""
) (
    input logic       clk,
    input logic       rst_n,
    bram_bus_if.slave bus
);
    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I} state_t;

    function automatic logic misaligned(input logic [1:0] oplen, input logic [1:0] lsb);
        return (oplen == 2'd1 && lsb[0]) || (oplen[1] && lsb != 2'b00);
    endfunction

    state_t        state_reg;
    logic [3:0]    cnt_reg;
    logic          q_d_reg, q_i_reg;
    logic [AW+1:0] d_addr_reg;
    logic          d_rw_reg, d_unsigned_reg;
    logic [1:0]    d_oplen_reg;
    logic [31:0]   d_wdata_reg;
    logic [AW-1:0] i_idx_reg;
    logic          instr_valid_reg, data_valid_reg, data_misaligned_reg;
    logic [31:0]   instr_result_reg, data_result_reg;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rdata_reg;

    logic accept_d, accept_i, free, avail_d, avail_i, start_d, start_i;
    assign accept_d = bus.data_enable && data_valid_reg;
    assign accept_i = bus.instr_enable && instr_valid_reg;
    assign free     = (state_reg == IDLE) || (cnt_reg == 4'd0);
    assign avail_d  = q_d_reg || accept_d;
    assign avail_i  = q_i_reg || accept_i;
    assign start_d  = rst_n && free && avail_d;
    assign start_i  = rst_n && free && !avail_d && avail_i;

    // A request starting on its acceptance edge uses the live inputs; a queued one uses the captured copy.
    logic [AW+1:0] sel_addr;
    logic [1:0]    sel_oplen;
    logic          sel_rw;
    logic [31:0]   sel_wdata;
    logic          sel_mis;
    logic [AW-1:0] mem_idx;
    assign sel_addr  = q_d_reg ? d_addr_reg  : bus.data_addr[AW+1:0];
    assign sel_oplen = q_d_reg ? d_oplen_reg : bus.data_oplen;
    assign sel_rw    = q_d_reg ? d_rw_reg    : bus.data_rw;
    assign sel_wdata = q_d_reg ? d_wdata_reg : bus.data_wdata;
    assign sel_mis   = misaligned(sel_oplen, sel_addr[1:0]);
    assign mem_idx   = start_d ? sel_addr[AW+1:2] :
                       (q_i_reg ? i_idx_reg : bus.instr_addr[AW+1:2]);

    logic [3:0]  be;
    logic [31:0] lane_data;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign be[gi] = start_d && sel_rw && !sel_mis &&
                ((sel_oplen == 2'd0) ? (sel_addr[1:0] == 2'(gi)) :
                 (sel_oplen == 2'd1) ? (sel_addr[1] == 1'(gi / 2)) : 1'b1);
            assign lane_data[8*gi +: 8] =
                (sel_oplen == 2'd0) ? sel_wdata[7:0] :
                (sel_oplen == 2'd1) ? sel_wdata[8*(gi % 2) +: 8] : sel_wdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (start_d || start_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[mem_idx][8*k +: 8] <= lane_data[8*k +: 8];
            end
            rdata_reg <= mem[mem_idx];
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_value;
    logic        done_mis;
    assign ld_byte  = rdata_reg[{d_addr_reg[1:0], 3'b000} +: 8];
    assign ld_half  = d_addr_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
    assign done_mis = misaligned(d_oplen_reg, d_addr_reg[1:0]);

    always_comb begin
        load_value = rdata_reg;
        if (d_oplen_reg == 2'd0)
            load_value = {{24{!d_unsigned_reg && ld_byte[7]}}, ld_byte};
        else if (d_oplen_reg == 2'd1)
            load_value = {{16{!d_unsigned_reg && ld_half[15]}}, ld_half};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= IDLE;
            cnt_reg             <= '0;
            q_d_reg             <= 1'b0;
            q_i_reg             <= 1'b0;
            d_addr_reg          <= '0;
            d_rw_reg            <= 1'b0;
            d_oplen_reg         <= '0;
            d_unsigned_reg      <= 1'b0;
            d_wdata_reg         <= '0;
            i_idx_reg           <= '0;
            instr_valid_reg     <= 1'b1;
            data_valid_reg      <= 1'b1;
            instr_result_reg    <= '0;
            data_result_reg     <= '0;
            data_misaligned_reg <= 1'b0;
        end else begin
            data_misaligned_reg <= 1'b0;
            if (accept_d) begin
                d_addr_reg     <= bus.data_addr[AW+1:0];
                d_rw_reg       <= bus.data_rw;
                d_oplen_reg    <= bus.data_oplen;
                d_unsigned_reg <= bus.data_unsigned;
                d_wdata_reg    <= bus.data_wdata;
                data_valid_reg <= 1'b0;
            end
            if (accept_i) begin
                i_idx_reg       <= bus.instr_addr[AW+1:2];
                instr_valid_reg <= 1'b0;
            end
            if (start_d)       q_d_reg <= 1'b0;
            else if (accept_d) q_d_reg <= 1'b1;
            if (start_i)       q_i_reg <= 1'b0;
            else if (accept_i) q_i_reg <= 1'b1;

            if (state_reg != IDLE) begin
                if (cnt_reg == 4'd0) begin
                    if (state_reg == SERVE_D) begin
                        data_valid_reg      <= 1'b1;
                        data_misaligned_reg <= done_mis;
                        if (done_mis)       data_result_reg <= '0;
                        else if (!d_rw_reg) data_result_reg <= load_value;
                    end else begin
                        instr_valid_reg  <= 1'b1;
                        instr_result_reg <= rdata_reg;
                    end
                end else begin
                    cnt_reg <= cnt_reg - 4'd1;
                end
            end

            if (start_d) begin
                state_reg <= SERVE_D;
                cnt_reg   <= CNT_INIT;
            end else if (start_i) begin
                state_reg <= SERVE_I;
                cnt_reg   <= CNT_INIT;
            end else if (free) begin
                state_reg <= IDLE;
            end
        end
    end

    assign bus.instr_valid     = instr_valid_reg;
    assign bus.instr_result    = instr_result_reg;
    assign bus.data_valid      = data_valid_reg;
    assign bus.data_result     = data_result_reg;
    assign bus.data_misaligned = data_misaligned_reg;
endmodule

// File: tb/tb_bram_bus_responder.sv
// Random and directed traffic against a byte-array/timeline model of the responder,
// plus a LATENCY=4 instance used for the mid-transaction reset scenario.
module tb_bram_bus_responder;
    localparam int L      = 2;
    localparam int L4     = 4;
    localparam int NBYTES = 256;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst4_n = 1'b0;
    always #5 clk = ~clk;

    bram_bus_if bus ();
    bram_bus_if bus4 ();

    bram_bus_responder #(.DEPTH_WORDS(64), .LATENCY(L), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    bram_bus_responder #(.DEPTH_WORDS(64), .LATENCY(L4), .INIT_FILE("")) dut4 (
        .clk(clk), .rst_n(rst4_n), .bus(bus4));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte memory, and a single server whose busy time is booked at acceptance.
    logic [7:0]  mem_b [NBYTES];
    int          ecount, d_done, i_done, srv_free;
    bit          d_busy, i_busy;
    logic        exp_iv, exp_dv, exp_mis, pd_mis;
    logic [31:0] exp_ires, exp_dres, pd_res, pi_res;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            ecount = 0; srv_free = 0; d_busy = 0; i_busy = 0;
            exp_iv = 1; exp_dv = 1; exp_mis = 0; exp_ires = 0; exp_dres = 0;
        end else begin : model_step
            bit          acc_d, acc_i;
            int          a, size, st;
            logic [31:0] v;
            acc_d = bus.data_enable && exp_dv;
            acc_i = bus.instr_enable && exp_iv;
            ecount++;
            exp_mis = 0;
            if (d_busy && ecount == d_done) begin
                exp_dv = 1; exp_dres = pd_res; exp_mis = pd_mis; d_busy = 0;
            end
            if (i_busy && ecount == i_done) begin
                exp_iv = 1; exp_ires = pi_res; i_busy = 0;
            end
            if (acc_d) begin
                size = (bus.data_oplen == 2'd0) ? 1 : (bus.data_oplen == 2'd1) ? 2 : 4;
                a = int'(bus.data_addr) % NBYTES;
                pd_mis = (a % size) != 0;
                if (pd_mis) begin
                    pd_res = 0;
                end else if (bus.data_rw) begin
                    pd_res = exp_dres;
                    for (int b = 0; b < size; b++) mem_b[a + b] = bus.data_wdata[8*b +: 8];
                end else begin
                    v = 0;
                    for (int b = 0; b < size; b++) v = v | (32'(mem_b[a + b]) << (8 * b));
                    if (!bus.data_unsigned && size < 4 && v[8*size-1])
                        v = v | ~((32'd1 << (8 * size)) - 32'd1);
                    pd_res = v;
                end
                st = (ecount > srv_free) ? ecount : srv_free;
                d_done = st + L; srv_free = d_done; d_busy = 1; exp_dv = 0;
            end
            if (acc_i) begin
                a = (int'(bus.instr_addr) % NBYTES) & ~3;
                pi_res = {mem_b[a + 3], mem_b[a + 2], mem_b[a + 1], mem_b[a]};
                st = (ecount > srv_free) ? ecount : srv_free;
                i_done = st + L; srv_free = i_done; i_busy = 1; exp_iv = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("instr_valid", 32'(bus.instr_valid), 32'(exp_iv));
            check("data_valid", 32'(bus.data_valid), 32'(exp_dv));
            check("data_misaligned", 32'(bus.data_misaligned), 32'(exp_mis));
            check("instr_result", bus.instr_result, exp_ires);
            check("data_result", bus.data_result, exp_dres);
        end
    end

    function automatic logic dvalid(input bit u4);
        return u4 ? bus4.data_valid : bus.data_valid;
    endfunction

    function automatic logic ivalid(input bit u4);
        return u4 ? bus4.instr_valid : bus.instr_valid;
    endfunction

    task automatic do_data(input bit u4, input bit rw, input logic [1:0] op, input bit uns,
                           input logic [24:0] addr, input logic [31:0] wd,
                           output int low, output logic [31:0] res, output logic mis);
        if (u4) begin
            bus4.data_rw = rw; bus4.data_oplen = op; bus4.data_unsigned = uns;
            bus4.data_addr = addr; bus4.data_wdata = wd; bus4.data_enable = 1'b1;
        end else begin
            bus.data_rw = rw; bus.data_oplen = op; bus.data_unsigned = uns;
            bus.data_addr = addr; bus.data_wdata = wd; bus.data_enable = 1'b1;
        end
        @(posedge clk); #1;
        if (u4) bus4.data_enable = 1'b0; else bus.data_enable = 1'b0;
        low = 0;
        while (!dvalid(u4) && low < 100) begin
            low++;
            @(posedge clk); #1;
        end
        res = u4 ? bus4.data_result : bus.data_result;
        mis = u4 ? bus4.data_misaligned : bus.data_misaligned;
    endtask

    task automatic do_fetch(input bit u4, input logic [24:0] addr,
                            output int low, output logic [31:0] res);
        if (u4) begin bus4.instr_addr = addr; bus4.instr_enable = 1'b1; end
        else    begin bus.instr_addr = addr;  bus.instr_enable = 1'b1;  end
        @(posedge clk); #1;
        if (u4) bus4.instr_enable = 1'b0; else bus.instr_enable = 1'b0;
        low = 0;
        while (!ivalid(u4) && low < 100) begin
            low++;
            @(posedge clk); #1;
        end
        res = u4 ? bus4.instr_result : bus.instr_result;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          low, dl, il;
        logic [31:0] res;
        logic        mis;

        bus.instr_enable = 0; bus.instr_addr = '0; bus.data_enable = 0; bus.data_rw = 0;
        bus.data_oplen = '0; bus.data_unsigned = 0; bus.data_addr = '0; bus.data_wdata = '0;
        bus4.instr_enable = 0; bus4.instr_addr = '0; bus4.data_enable = 0; bus4.data_rw = 0;
        bus4.data_oplen = '0; bus4.data_unsigned = 0; bus4.data_addr = '0; bus4.data_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd1);
        check("rst_data_valid", 32'(bus.data_valid), 32'd1);
        check("rst_instr_result", bus.instr_result, 32'd0);
        check("rst_data_result", bus.data_result, 32'd0);
        rst_n = 1'b1; rst4_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 64; w++)
            do_data(0, 1'b1, 2'd2, 1'b0, 25'(w * 4), $urandom, low, res, mis);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.instr_enable  = ($urandom_range(0, 2) != 0);
            bus.instr_addr    = 25'($urandom);
            bus.data_enable   = ($urandom_range(0, 2) != 0);
            bus.data_rw       = 1'($urandom_range(0, 1));
            bus.data_oplen    = 2'($urandom_range(0, 3));
            bus.data_unsigned = 1'($urandom_range(0, 1));
            bus.data_addr     = 25'($urandom);
            bus.data_wdata    = $urandom;
        end
        @(posedge clk); #1;
        bus.instr_enable = 0; bus.data_enable = 0;
        repeat (20) @(posedge clk);
        #1;

        do_data(0, 1'b1, 2'd2, 1'b0, 25'h0, 32'h00500093, low, res, mis);
        do_fetch(0, 25'h0, low, res);
        check("fetch_low_cycles", 32'(low), 32'd2);
        check("fetch_result", res, 32'h00500093);

        do_data(0, 1'b1, 2'd2, 1'b0, 25'h10, 32'hDEADBEEF, low, res, mis);
        do_data(0, 1'b0, 2'd0, 1'b1, 25'h11, 32'h0, low, res, mis);
        check("lbu_0x11", res, 32'h000000BE);
        check("load_low_cycles", 32'(low), 32'd2);
        do_data(0, 1'b0, 2'd0, 1'b0, 25'h11, 32'h0, low, res, mis);
        check("lb_0x11", res, 32'hFFFFFFBE);
        do_data(0, 1'b0, 2'd1, 1'b0, 25'h12, 32'h0, low, res, mis);
        check("lh_0x12", res, 32'hFFFFDEAD);
        do_data(0, 1'b1, 2'd0, 1'b0, 25'h13, 32'h0000005A, low, res, mis);
        do_data(0, 1'b0, 2'd2, 1'b0, 25'h10, 32'h0, low, res, mis);
        check("lw_after_sb", res, 32'h5AADBEEF);

        bus.data_rw = 0; bus.data_oplen = 2'd2; bus.data_unsigned = 0; bus.data_addr = 25'h10;
        bus.instr_addr = 25'h0; bus.data_enable = 1; bus.instr_enable = 1;
        @(posedge clk); #1;
        bus.data_enable = 0; bus.instr_enable = 0;
        dl = 0; il = 0;
        for (int c = 0; c < 10; c++) begin
            if (!bus.data_valid) dl++;
            if (!bus.instr_valid) il++;
            @(posedge clk); #1;
        end
        check("contend_data_low", 32'(dl), 32'd2);
        check("contend_instr_low", 32'(il), 32'd4);
        check("contend_data_result", bus.data_result, 32'h5AADBEEF);
        check("contend_instr_result", bus.instr_result, 32'h00500093);

        do_data(0, 1'b1, 2'd2, 1'b0, 25'h20, 32'h11223344, low, res, mis);
        do_data(0, 1'b1, 2'd2, 1'b0, 25'h22, 32'hCAFEF00D, low, res, mis);
        check("misaligned_pulse", 32'(mis), 32'd1);
        check("misaligned_result", res, 32'd0);
        check("misaligned_low_cycles", 32'(low), 32'd2);
        do_data(0, 1'b0, 2'd2, 1'b0, 25'h20, 32'h0, low, res, mis);
        check("misaligned_no_write", res, 32'h11223344);
        check("aligned_no_pulse", 32'(mis), 32'd0);

        do_data(1, 1'b1, 2'd2, 1'b0, 25'h4, 32'hA5A5A5A5, low, res, mis);
        do_data(1, 1'b0, 2'd2, 1'b0, 25'h4, 32'h0, low, res, mis);
        check("l4_load", res, 32'hA5A5A5A5);
        check("l4_load_low", 32'(low), 32'd4);
        do_fetch(1, 25'h4, low, res);
        check("l4_fetch", res, 32'hA5A5A5A5);
        bus4.data_rw = 1; bus4.data_oplen = 2'd2; bus4.data_addr = 25'h8;
        bus4.data_wdata = 32'h12345678; bus4.data_enable = 1;
        @(posedge clk); #1;
        bus4.data_enable = 0;
        @(posedge clk); #1;
        check("l4_busy_before_reset", 32'(bus4.data_valid), 32'd0);
        rst4_n = 1'b0;
        #1;
        check("l4_reset_data_valid", 32'(bus4.data_valid), 32'd1);
        check("l4_reset_instr_valid", 32'(bus4.instr_valid), 32'd1);
        check("l4_reset_data_result", bus4.data_result, 32'd0);
        check("l4_reset_instr_result", bus4.instr_result, 32'd0);
        check("l4_reset_misaligned", 32'(bus4.data_misaligned), 32'd0);
        @(negedge clk); @(negedge clk);
        rst4_n = 1'b1;
        @(negedge clk);
        do_fetch(1, 25'h8, low, res);
        check("l4_fetch_after_reset_low", 32'(low), 32'd4);
        check("l4_store_retained", res, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
